// File: rtl/axis_counter_source_if.sv
// ============================================================================
// Module      : axis_counter_source_if
// Description : AXI-Stream beat bundle (tdata/tvalid/tready/tlast) with
//               master and slave modports.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface axis_counter_source_if #(
    parameter int c_WIDTH = 8
);
    logic [c_WIDTH-1:0] tdata;
    logic               tvalid;
    logic               tready;
    logic               tlast;

    modport master (
        output tdata,
        output tvalid,
        output tlast,
        input  tready
    );

    modport slave (
        input  tdata,
        input  tvalid,
        input  tlast,
        output tready
    );
endinterface

`default_nettype wire

// File: rtl/axis_counter_source.sv
// ============================================================================
// Module      : axis_counter_source
// Description : AXI-Stream packet source emitting a programmed number of
//               fixed-length packets whose payload is a free-running counter.
//               Optional inter-packet gap enabled by AXIS_COUNTER_SOURCE_GAP_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module axis_counter_source #(
    parameter int c_WIDTH     = 8,
    parameter int c_LEN_WIDTH = 8,
    parameter int c_CNT_WIDTH = 16
) (
    input  wire logic                   clk,
    input  wire logic                   rst,
    input  wire logic                   i_start,
    input  wire logic                   i_stop,
    input  wire logic [c_LEN_WIDTH-1:0] i_pkt_len,
    input  wire logic [c_CNT_WIDTH-1:0] i_pkt_count,
`ifdef AXIS_COUNTER_SOURCE_GAP_EN
    input  wire logic [7:0]             i_gap_len,
`endif
    output logic                        o_busy,
    output logic                        o_done,
    output logic [c_CNT_WIDTH-1:0]      o_pkts_sent,
    axis_counter_source_if.master       m_axis
);

`ifdef AXIS_COUNTER_SOURCE_GAP_EN
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SEND = 2'd1,
        S_DONE = 2'd2,
        S_GAP  = 2'd3
    } state_t;
`else
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SEND = 2'd1,
        S_DONE = 2'd2
    } state_t;
`endif

    state_t                 r_state;
    state_t                 w_next;

    logic [c_WIDTH-1:0]     r_tdata;
    logic [c_LEN_WIDTH-1:0] r_beat;
    logic [c_LEN_WIDTH-1:0] r_last_idx;
    logic [c_CNT_WIDTH-1:0] r_count;
    logic [c_CNT_WIDTH-1:0] r_pkts_sent;

    logic                   w_tvalid;
    logic                   w_tlast;
    logic                   w_xfer;
    logic                   w_last_xfer;
    logic                   w_end;
    logic [c_CNT_WIDTH-1:0] w_pkts_next;

`ifdef AXIS_COUNTER_SOURCE_GAP_EN
    logic [7:0]             r_gap_len;
    logic [7:0]             r_gap_cnt;
    logic                   r_gap_stop;
`endif

    assign w_xfer      = w_tvalid && m_axis.tready;
    assign w_last_xfer = w_xfer && w_tlast;
    assign w_pkts_next = r_pkts_sent + 1'b1;
    // A run of pkt_count==0 never ends on count, only on stop.
    assign w_end       = ((r_count != '0) && (w_pkts_next == r_count)) || i_stop;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next   = r_state;
        w_tvalid = 1'b0;
        w_tlast  = 1'b0;
        o_busy   = (r_state != S_IDLE);
        o_done   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    w_next = S_SEND;
                end
            end
            S_SEND: begin
                w_tvalid = 1'b1;
                w_tlast  = (r_beat == r_last_idx);
                if (w_last_xfer) begin
                    if (w_end) begin
                        w_next = S_DONE;
`ifdef AXIS_COUNTER_SOURCE_GAP_EN
                    end else if (r_gap_len != 8'd0) begin
                        w_next = S_GAP;
`endif
                    end else begin
                        w_next = S_SEND;
                    end
                end
            end
            S_DONE: begin
                o_done = 1'b1;
                w_next = S_IDLE;
            end
`ifdef AXIS_COUNTER_SOURCE_GAP_EN
            S_GAP: begin
                // Stop seen at any point of the gap ends the run once it expires.
                if (r_gap_cnt <= 8'd1) begin
                    w_next = (r_gap_stop || i_stop) ? S_DONE : S_SEND;
                end
            end
`endif
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tdata     <= '0;
            r_beat      <= '0;
            r_last_idx  <= '0;
            r_count     <= '0;
            r_pkts_sent <= '0;
        end else begin
            if ((r_state == S_IDLE) && i_start) begin
                r_last_idx  <= (i_pkt_len == '0) ? '0 : (i_pkt_len - 1'b1);
                r_count     <= i_pkt_count;
                r_pkts_sent <= '0;
                r_tdata     <= '0;
                r_beat      <= '0;
            end else if (w_xfer) begin
                r_tdata <= r_tdata + 1'b1;
                if (w_tlast) begin
                    r_beat      <= '0;
                    r_pkts_sent <= w_pkts_next;
                end else begin
                    r_beat <= r_beat + 1'b1;
                end
            end
        end
    end

`ifdef AXIS_COUNTER_SOURCE_GAP_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_gap_len  <= '0;
            r_gap_cnt  <= '0;
            r_gap_stop <= 1'b0;
        end else begin
            if ((r_state == S_IDLE) && i_start) begin
                r_gap_len <= i_gap_len;
            end
            if ((r_state == S_SEND) && (w_next == S_GAP)) begin
                r_gap_cnt  <= r_gap_len;
                r_gap_stop <= 1'b0;
            end else if (r_state == S_GAP) begin
                r_gap_cnt  <= r_gap_cnt - 1'b1;
                r_gap_stop <= r_gap_stop | i_stop;
            end
        end
    end
`endif

    assign o_pkts_sent   = r_pkts_sent;
    assign m_axis.tdata  = r_tdata;
    assign m_axis.tvalid = w_tvalid;
    assign m_axis.tlast  = w_tlast;

endmodule

`default_nettype wire

// File: tb/tb_axis_counter_source.sv
// ============================================================================
// Module      : tb_axis_counter_source
// Description : Scoreboard bench for axis_counter_source.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_axis_counter_source;

    logic        clk;
    logic        rst;
    logic        start;
    logic        stop;
    logic [7:0]  pkt_len;
    logic [15:0] pkt_count;
    logic        busy;
    logic        done;
    logic [15:0] pkts_sent;
`ifdef AXIS_COUNTER_SOURCE_GAP_EN
    logic [7:0]  gap_len;
`endif

    axis_counter_source_if #(.c_WIDTH(8)) u_if ();

    axis_counter_source #(
        .c_WIDTH    (8),
        .c_LEN_WIDTH(8),
        .c_CNT_WIDTH(16)
    ) u_dut (
        .clk        (clk),
        .rst        (rst),
        .i_start    (start),
        .i_stop     (stop),
        .i_pkt_len  (pkt_len),
        .i_pkt_count(pkt_count),
`ifdef AXIS_COUNTER_SOURCE_GAP_EN
        .i_gap_len  (gap_len),
`endif
        .o_busy     (busy),
        .o_done     (done),
        .o_pkts_sent(pkts_sent),
        .m_axis     (u_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int last_tlast_cyc = -100;

    logic [8:0] exp_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Scoreboard monitor: every accepted beat is matched against the queue head.
    logic       prev_stall = 1'b0;
    logic [8:0] prev_beat  = '0;
    always @(negedge clk) begin
        logic [8:0] got;
        logic [8:0] exp;
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            got = {u_if.tlast, u_if.tdata};
            if (prev_stall) begin
                check("stall_valid", {31'd0, u_if.tvalid}, 32'd1);
                check("stall_hold", {23'd0, got}, {23'd0, prev_beat});
            end
            if (u_if.tvalid && u_if.tready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_beat", {23'd0, got}, 32'h1ff);
                end else begin
                    exp = exp_q.pop_front();
                    check("beat", {23'd0, got}, {23'd0, exp});
                end
                if (u_if.tlast) last_tlast_cyc = cyc;
            end
            prev_stall = u_if.tvalid && !u_if.tready;
            prev_beat  = got;
        end
    end

    task automatic push_run(input int len, input int npkts);
        int l;
        l = (len == 0) ? 1 : len;
        for (int i = 0; i < l * npkts; i++) begin
            exp_q.push_back({((i % l) == l - 1) ? 1'b1 : 1'b0, 8'(i)});
        end
    endtask

    task automatic do_start(input logic [7:0] len, input logic [15:0] cnt);
        @(posedge clk); #1;
        pkt_len   = len;
        pkt_count = cnt;
        start     = 1'b1;
        @(negedge clk);
        check("lat_pre_valid", {31'd0, u_if.tvalid}, 32'd0);
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        check("lat_post_valid", {31'd0, u_if.tvalid}, 32'd1);
    endtask

    task automatic wait_done(input int budget, input logic [15:0] exp_sent);
        bit seen = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (done) begin
                seen = 1;
                break;
            end
        end
        check("done_seen", {31'd0, seen}, 32'd1);
        if (seen) begin
            check("done_latency", cyc, last_tlast_cyc + 1);
            @(negedge clk);
            check("done_pulse_width", {31'd0, done}, 32'd0);
            check("busy_after", {31'd0, busy}, 32'd0);
            check("pkts_sent", {16'd0, pkts_sent}, {16'd0, exp_sent});
        end
        check("queue_drained", exp_q.size(), 0);
    endtask

    initial begin
        logic [5:0] pat;
        bit         hit;
        rst = 1'b1; start = 1'b0; stop = 1'b0;
        pkt_len = '0; pkt_count = '0;
        u_if.tready = 1'b1;
`ifdef AXIS_COUNTER_SOURCE_GAP_EN
        gap_len = '0;
`endif
        repeat (3) @(posedge clk);
        #1;
        check("rst_outputs", {busy, done, u_if.tvalid, u_if.tlast, u_if.tdata, pkts_sent},
              32'd0);
        rst = 1'b0;

        // Basic: 2 packets of 4 beats
        push_run(4, 2);
        do_start(8'd4, 16'd2);
        wait_done(50, 16'd2);

        // Backpressure: 3 beats, ready pattern 1,0,0,1,0,1
        pat = 6'b101001;
        push_run(3, 1);
        u_if.tready = 1'b1;
        do_start(8'd3, 16'd1);
        for (int k = 1; k < 6; k++) begin
            @(posedge clk); #1;
            u_if.tready = pat[k];
        end
        @(posedge clk); #1;
        u_if.tready = 1'b1;
        wait_done(50, 16'd1);

        // Counter wrap across a 200-beat packet boundary
        push_run(200, 2);
        do_start(8'd200, 16'd2);
        wait_done(500, 16'd2);

        // Continuous with stop raised mid third packet
        push_run(5, 3);
        do_start(8'd5, 16'd0);
        hit = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (pkts_sent == 16'd2) begin
                hit = 1;
                break;
            end
        end
        check("reach_pkt2", {31'd0, hit}, 32'd1);
        @(posedge clk); #1;
        stop = 1'b1;
        wait_done(50, 16'd3);
        stop = 1'b0;

        // Reset mid-packet after beats 0 and 1, then restart
        exp_q.push_back({1'b0, 8'd0});
        exp_q.push_back({1'b0, 8'd1});
        do_start(8'd8, 16'd1);
        @(posedge clk);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_outputs",
              {busy, done, u_if.tvalid, u_if.tlast, u_if.tdata, pkts_sent}, 32'd0);
        check("rst_queue", exp_q.size(), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        push_run(2, 1);
        do_start(8'd2, 16'd1);
        wait_done(50, 16'd1);

        // pkt_len=0 behaves as single-beat packets
        push_run(0, 2);
        do_start(8'd0, 16'd2);
        wait_done(50, 16'd2);

`ifdef AXIS_COUNTER_SOURCE_GAP_EN
        begin
            int low_cnt;
            bit seen_valid;
            low_cnt = 0;
            seen_valid = 0;
            push_run(2, 3);
            @(posedge clk); #1;
            gap_len = 8'd3;
            do_start(8'd2, 16'd3);
            seen_valid = 1;
            hit = 0;
            for (int i = 0; i < 60; i++) begin
                @(negedge clk);
                if (done) begin
                    hit = 1;
                    break;
                end
                if (seen_valid && !u_if.tvalid) low_cnt++;
            end
            check("gap_done", {31'd0, hit}, 32'd1);
            check("gap_low_cycles", low_cnt, 6);
            check("gap_done_latency", cyc, last_tlast_cyc + 1);
            check("gap_pkts", {16'd0, pkts_sent}, 32'd3);
            check("gap_queue", exp_q.size(), 0);
            gap_len = 8'd0;
        end
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
